// File: rtl/jtag_scan_seq_if.sv
// Command/response bundle between a scan requester and jtag_scan_seq.
// Signal suffixes are named from the sequencer's point of view.
interface jtag_scan_seq_if #(
   parameter int MAX_LEN = 64
);
   logic               cmd_valid_i;
   logic               cmd_ready_o;
   logic               cmd_ir_i;
   logic [6:0]         cmd_len_i;
   logic [MAX_LEN-1:0] cmd_data_i;
   logic               rsp_valid_o;
   logic               rsp_ready_i;
   logic [MAX_LEN-1:0] rsp_data_o;

   modport master (
      output cmd_valid_i, cmd_ir_i, cmd_len_i, cmd_data_i,
      output rsp_ready_i,
      input  cmd_ready_o, rsp_valid_o, rsp_data_o
   );

   modport slave (
      input  cmd_valid_i, cmd_ir_i, cmd_len_i, cmd_data_i,
      input  rsp_ready_i,
      output cmd_ready_o, rsp_valid_o, rsp_data_o
   );
endinterface

// File: rtl/jtag_scan_seq.sv
// JTAG scan sequencer: turns IR/DR scan commands into TCK/TMS/TDI slots
// and returns captured TDO; the TAP is parked in Run-Test/Idle between scans.
module jtag_scan_seq #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   jtag_scan_seq_if.slave bus,
   output logic           busy_o,
   output logic           jtag_tck_o,
   output logic           jtag_tms_o,
   output logic           jtag_tdi_o,
   input  logic           jtag_tdo_i,
   output logic           jtag_trst_no
);
   localparam int LW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int PW = $clog2(2 * CLK_DIV) + 1;
   localparam logic [PW-1:0] PH_RISE = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] PH_END  = PW'(2 * CLK_DIV - 1);
   localparam logic [6:0]    LEN_MAX = 7'(MAX_LEN);

   typedef enum logic [2:0] {
      S_TRST, S_IDLE, S_PRE, S_SHIFT, S_UPD, S_FIN, S_RESP
   } state_e;

   state_e             st_q;
   logic [PW-1:0]      ph_q;
   logic [6:0]         slot_q;
   logic [6:0]         len_q;
   logic               ir_q;
   logic               rstcmd_q;
   logic [MAX_LEN-1:0] data_q;
   logic [MAX_LEN-1:0] cap_q;
   logic [MAX_LEN-1:0] rsp_data_q;
   logic               tck_q, tms_q, tdi_q, trst_q;
   logic               rdy_q, rvld_q;

   state_e     nst_d;
   logic [6:0] nslot_d;
   logic [6:0] last_slot;
   logic [6:0] len_clamp;
   logic       ntms_d, ntdi_d;

   assign len_clamp = (bus.cmd_len_i > LEN_MAX) ? LEN_MAX : bus.cmd_len_i;

   // Where the engine goes at the end of the current slot.
   always_comb begin
      last_slot = 7'd0;
      nst_d     = st_q;
      nslot_d   = slot_q + 7'd1;
      unique case (st_q)
         S_TRST:  last_slot = 7'd5;
         S_PRE:   last_slot = ir_q ? 7'd3 : 7'd2;
         S_SHIFT: last_slot = len_q - 7'd1;
         S_UPD:   last_slot = 7'd1;
         default: last_slot = 7'd0;
      endcase
      if (slot_q == last_slot) begin
         nslot_d = 7'd0;
         unique case (st_q)
            S_TRST:  nst_d = rstcmd_q ? S_FIN : S_IDLE;
            S_PRE:   nst_d = S_SHIFT;
            S_SHIFT: nst_d = S_UPD;
            S_UPD:   nst_d = S_FIN;
            default: nst_d = st_q;
         endcase
      end
      unique case (nst_d)
         S_TRST:  ntms_d = (nslot_d < 7'd5);
         S_PRE:   ntms_d = (nslot_d == 7'd0) ||
                           (ir_q && nslot_d == 7'd1);
         S_SHIFT: ntms_d = (nslot_d == len_q - 7'd1);
         S_UPD:   ntms_d = (nslot_d == 7'd0);
         default: ntms_d = 1'b0;
      endcase
      ntdi_d = (nst_d == S_SHIFT) ? data_q[nslot_d[LW-1:0]] : 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q       <= S_TRST;
         ph_q       <= '0;
         slot_q     <= '0;
         len_q      <= '0;
         ir_q       <= 1'b0;
         rstcmd_q   <= 1'b0;
         data_q     <= '0;
         cap_q      <= '0;
         rsp_data_q <= '0;
         tck_q      <= 1'b0;
         tms_q      <= 1'b1;
         tdi_q      <= 1'b0;
         trst_q     <= 1'b0;
         rdy_q      <= 1'b0;
         rvld_q     <= 1'b0;
      end else begin
         trst_q <= 1'b1;
         unique case (st_q)
            S_IDLE: begin
               if (bus.cmd_valid_i && rdy_q) begin
                  rdy_q    <= 1'b0;
                  len_q    <= len_clamp;
                  ir_q     <= bus.cmd_ir_i;
                  data_q   <= bus.cmd_data_i;
                  rstcmd_q <= (bus.cmd_len_i == 7'd0);
                  cap_q    <= '0;
                  slot_q   <= '0;
                  ph_q     <= '0;
                  tms_q    <= 1'b1;
                  tdi_q    <= 1'b0;
                  st_q     <= (bus.cmd_len_i == 7'd0) ? S_TRST : S_PRE;
               end
            end
            S_FIN: begin
               rsp_data_q <= cap_q;
               rvld_q     <= 1'b1;
               st_q       <= S_RESP;
            end
            S_RESP: begin
               if (bus.rsp_ready_i) begin
                  rvld_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  st_q   <= S_IDLE;
               end
            end
            default: begin
               if (ph_q == PH_END) begin
                  ph_q   <= '0;
                  tck_q  <= 1'b0;
                  slot_q <= nslot_d;
                  st_q   <= nst_d;
                  tms_q  <= ntms_d;
                  tdi_q  <= ntdi_d;
                  if (nst_d == S_IDLE) rdy_q <= 1'b1;
               end else begin
                  ph_q <= ph_q + PW'(1);
                  // TDO is taken on the same clk edge that raises TCK.
                  if (ph_q == PH_RISE) begin
                     tck_q <= 1'b1;
                     if (st_q == S_SHIFT)
                        cap_q[slot_q[LW-1:0]] <= jtag_tdo_i;
                  end
               end
            end
         endcase
      end
   end

   assign bus.cmd_ready_o = rdy_q;
   assign bus.rsp_valid_o = rvld_q;
   assign bus.rsp_data_o  = rsp_data_q;
   assign busy_o          = (st_q != S_IDLE);
   assign jtag_tck_o      = tck_q;
   assign jtag_tms_o      = tms_q;
   assign jtag_tdi_o      = tdi_q;
   assign jtag_trst_no    = trst_q;
endmodule

// File: tb/tb_jtag_scan_seq.sv
// Bench for jtag_scan_seq: TAP state model on the pins, scoreboard on the
// response channel, directed scans with hand-computed results.
module tb_jtag_scan_seq;
   localparam int ML = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtag_scan_seq_if #(.MAX_LEN(ML)) bus();
   logic busy, tck, tms, tdi, tdo, trst_n;

   jtag_scan_seq #(.CLK_DIV(2), .MAX_LEN(ML)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .busy_o(busy),
      .jtag_tck_o(tck), .jtag_tms_o(tms), .jtag_tdi_o(tdi),
      .jtag_tdo_i(tdo), .jtag_trst_no(trst_n)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(string nm);
      checks++;
      errs++;
      $display("FAIL %s: bound expired", nm);
   endtask

   typedef enum logic [3:0] {
      TLR, RTI, SDR, CDR, SHDR, E1DR, PDR, E2DR, UDR,
      SIR, CIR, SHIR, E1IR, PIR, E2IR, UIR
   } tap_e;

   tap_e        tap = TLR;
   logic [63:0] dr_sr = '0;
   logic [4:0]  ir_sr = '0;
   logic [63:0] dr_cap = '0;
   logic        loop = 1'b0;
   logic        tms_tr[$];
   logic        tdi_tr[$];
   int          rises = 0;

   always @(posedge tck or negedge trst_n) begin
      if (!trst_n) tap <= TLR;
      else begin
         case (tap)
            CDR:  dr_sr <= dr_cap;
            SHDR: dr_sr <= {tdi, dr_sr[63:1]};
            CIR:  ir_sr <= 5'b00001;
            SHIR: ir_sr <= {tdi, ir_sr[4:1]};
            default: ;
         endcase
         case (tap)
            TLR:  tap <= tms ? TLR  : RTI;
            RTI:  tap <= tms ? SDR  : RTI;
            SDR:  tap <= tms ? SIR  : CDR;
            CDR:  tap <= tms ? E1DR : SHDR;
            SHDR: tap <= tms ? E1DR : SHDR;
            E1DR: tap <= tms ? UDR  : PDR;
            PDR:  tap <= tms ? E2DR : PDR;
            E2DR: tap <= tms ? UDR  : SHDR;
            UDR:  tap <= tms ? SDR  : RTI;
            SIR:  tap <= tms ? TLR  : CIR;
            CIR:  tap <= tms ? E1IR : SHIR;
            SHIR: tap <= tms ? E1IR : SHIR;
            E1IR: tap <= tms ? UIR  : PIR;
            PIR:  tap <= tms ? E2IR : PIR;
            E2IR: tap <= tms ? UIR  : SHIR;
            default: tap <= tms ? SDR : RTI;
         endcase
      end
   end

   always @(posedge tck) begin
      tms_tr.push_back(tms);
      tdi_tr.push_back(tdi);
      rises++;
   end

   assign tdo = loop ? tdi :
                (tap == SHDR) ? dr_sr[0] :
                (tap == SHIR) ? ir_sr[0] : 1'b0;

   typedef struct {
      logic [63:0] data;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   lat_obs = 0;
   bit   lat_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rsp_valid_o && !lat_seen) begin
         lat_seen = 1;
         lat_obs  = cyc - hs_cyc;
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
         if (sbq.size() == 0) fail_now("unexpected_rsp");
         else begin
            e = sbq.pop_front();
            chk("rsp_data", bus.rsp_data_o, e.data);
            if (e.lat > 0) chk("rsp_latency", 64'(lat_obs), 64'(e.lat));
         end
         lat_seen = 0;
      end
   end

   function automatic logic [63:0] pack(input logic q[$], input int lo,
                                        input int n);
      logic [63:0] v = '0;
      for (int i = 0; i < n; i++)
         if (lo + i < q.size()) v[i] = q[lo + i];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_trace();
      tms_tr.delete();
      tdi_tr.delete();
      rises = 0;
   endtask

   task automatic send(input logic ir, input logic [6:0] len,
                       input logic [63:0] d, input logic [63:0] exp,
                       input int lat);
      int n = 0;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_ir_i    = ir;
      bus.cmd_len_i   = len;
      bus.cmd_data_i  = d;
      while (!bus.cmd_ready_o && n < 2000) begin
         tick();
         n++;
      end
      if (!bus.cmd_ready_o) fail_now("cmd_accept");
      else begin
         hs_cyc = cyc + 1;
         sbq.push_back('{data: exp, lat: lat});
      end
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!bus.rsp_valid_o && n < 3000) begin
         tick();
         n++;
      end
      if (!bus.rsp_valid_o) fail_now("rsp_valid_wait");
   endtask

   task automatic wait_rsp(input int hold, input logic [63:0] expd);
      bit ok_v = 1, ok_d = 1, ok_r = 1;
      int r0;
      wait_valid();
      r0 = rises;
      repeat (hold) begin
         tick();
         ok_v &= bus.rsp_valid_o;
         ok_d &= (bus.rsp_data_o == expd);
         ok_r &= !bus.cmd_ready_o;
      end
      if (hold > 0) begin
         chk("hold_valid", 64'(ok_v), 64'd1);
         chk("hold_data", 64'(ok_d), 64'd1);
         chk("hold_cmd_ready_low", 64'(ok_r), 64'd1);
         chk("hold_no_tck", 64'(rises - r0), 64'd0);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!bus.cmd_ready_o && n < 500) begin
         tick();
         n++;
      end
      if (!bus.cmd_ready_o) fail_now("cmd_ready_wait");
   endtask

   initial begin
      logic [63:0] ones;
      ones = '1;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_ir_i    = 1'b0;
      bus.cmd_len_i   = '0;
      bus.cmd_data_i  = '0;
      bus.rsp_ready_i = 1'b0;
      repeat (3) tick();

      chk("reset_pins", {tck, tms, tdi, trst_n, bus.cmd_ready_o,
                         bus.rsp_valid_o, busy}, 7'b0100001);
      chk("reset_rsp_data", bus.rsp_data_o, 64'd0);

      // Reset release and automatic TRST.
      clr_trace();
      rst = 1'b0;
      chk("trst_before_edge", 64'(trst_n), 64'd0);
      tick();
      chk("trst_rise", 64'(trst_n), 64'd1);
      wait_ready();
      chk("trst_rises", 64'(rises), 64'd6);
      chk("trst_tms", pack(tms_tr, 0, 6), 64'h1F);
      chk("trst_tap", 64'(tap), 64'(RTI));

      // DR len=8 loopback.
      loop = 1'b1;
      send(1'b0, 7'd8, 64'hA5, 64'hA5, 53);
      wait_rsp(0, 64'h0);
      chk("dr8_tap", 64'(tap), 64'(RTI));

      // IR len=5 against the IR capture pattern.
      loop = 1'b0;
      clr_trace();
      send(1'b1, 7'd5, 64'h01, 64'h01, 45);
      wait_rsp(0, 64'h0);
      chk("ir5_rises", 64'(rises), 64'd11);
      chk("ir5_tms", pack(tms_tr, 0, 11), 64'h303);
      chk("ir5_tdi", pack(tdi_tr, 4, 5), 64'h01);
      chk("ir5_tap", 64'(tap), 64'(RTI));

      // DR len=32 against an IDCODE capture.
      dr_cap = 64'h13631093;
      send(1'b0, 7'd32, 64'h0, 64'h13631093, 149);
      wait_rsp(0, 64'h0);

      // Response back-pressure.
      loop = 1'b1;
      send(1'b0, 7'd16, 64'hBEEF, 64'hBEEF, 85);
      wait_rsp(20, 64'hBEEF);

      // Length-0 TAP reset command.
      clr_trace();
      send(1'b0, 7'd0, 64'hFFFF, 64'h0, 25);
      wait_rsp(0, 64'h0);
      chk("rstcmd_tms", pack(tms_tr, 0, 6), 64'h1F);
      chk("rstcmd_tap", 64'(tap), 64'(RTI));

      // Single-bit DR: the only shift slot exits with TMS=1.
      clr_trace();
      send(1'b0, 7'd1, 64'h1, 64'h1, 25);
      wait_rsp(0, 64'h0);
      chk("len1_tms", pack(tms_tr, 0, 6), 64'h19);

      // Length above MAX_LEN is clamped.
      send(1'b0, 7'd100, ones, ones, 277);
      wait_rsp(0, 64'h0);

      // rsp handshake and new command in the same cycle.
      send(1'b0, 7'd4, 64'hC, 64'hC, 37);
      wait_valid();
      bus.rsp_ready_i = 1'b1;
      bus.cmd_valid_i = 1'b1;
      bus.cmd_ir_i    = 1'b0;
      bus.cmd_len_i   = 7'd2;
      bus.cmd_data_i  = 64'h3;
      tick();
      bus.rsp_ready_i = 1'b0;
      chk("overlap_not_taken", {62'd0, bus.cmd_ready_o, busy}, 64'h2);
      hs_cyc = cyc + 1;
      sbq.push_back('{data: 64'h3, lat: 29});
      tick();
      bus.cmd_valid_i = 1'b0;
      chk("overlap_taken", 64'(busy), 64'd1);
      wait_rsp(0, 64'h0);

      // Reset in the middle of a long shift.
      send(1'b0, 7'd64, 64'h5555, 64'h5555, 0);
      repeat (60) tick();
      rst = 1'b1;
      tick();
      chk("midrst_pins", {60'd0, tck, tms, bus.rsp_valid_o, trst_n},
          64'h4);
      sbq.delete();
      lat_seen = 0;
      tick();
      clr_trace();
      rst = 1'b0;
      wait_ready();
      chk("midrst_trst_tms", pack(tms_tr, 0, 6), 64'h1F);
      chk("midrst_tap", 64'(tap), 64'(RTI));
      send(1'b0, 7'd64, ones, ones, 277);
      wait_rsp(0, 64'h0);
      chk("sb_empty", 64'(sbq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
